// File: rtl/bcm_bitplane_packer.sv
// Transposes a 16x64 raster of 8-bit pixels into 64-bit bitplane words and
// writes them to the BCM bitplane RAM at plane*ROWS + row, one frame at a time.
module bcm_bitplane_packer #(
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned PLANES = 8,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PLANES-1:0] pix_data,
  input  logic              pix_sof,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [COLS-1:0]   wr_data,
  output logic              frame_done,
  input  logic              frame_ack,
  output logic              sync_err
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned PL_W  = $clog2(PLANES);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PL_W-1:0]  plane;
  logic [PL_W-1:0]  plane_nxt;
  logic [COLS-1:0]  acc     [PLANES];
  logic [COLS-1:0]  acc_upd [PLANES];
  logic [COL_W-1:0] col_eff;
  logic [COL_W-1:0] bit_idx;
  logic             xfer;

  assign xfer      = pix_valid & pix_ready;
  assign plane_nxt = plane + PL_W'(1);
  // A start-of-frame pixel always lands in column 0 (MSB of each word).
  assign col_eff   = pix_sof ? '0 : col;
  assign bit_idx   = COL_W'(COLS - 1) - col_eff;

  // Accumulators with the pixel on the bus merged in.
  always_comb begin
    for (int p = 0; p < int'(PLANES); p++) begin
      acc_upd[p]          = acc[p];
      acc_upd[p][bit_idx] = pix_data[p];
    end
  end

  function automatic logic [ADDR_W-1:0] addr_of(input logic [PL_W-1:0] pl,
                                                input logic [ROW_W-1:0] rw);
    return ADDR_W'(pl) * ADDR_W'(ROWS) + ADDR_W'(rw);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      pix_ready  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      for (int p = 0; p < int'(PLANES); p++) acc[p] <= '0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (xfer && pix_sof) begin
            for (int p = 0; p < int'(PLANES); p++) acc[p] <= acc_upd[p];
            row   <= '0;
            col   <= COL_W'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          pix_ready <= 1'b1;
          if (xfer) begin
            for (int p = 0; p < int'(PLANES); p++) acc[p] <= acc_upd[p];
            if (pix_sof && (row != '0 || col != '0)) begin
              sync_err <= 1'b1;
              row      <= '0;
              col      <= COL_W'(1);
            end else if (col == COL_W'(COLS - 1)) begin
              // Plane 0 goes out on the very next cycle, straight from the merged word.
              col       <= '0;
              plane     <= '0;
              pix_ready <= 1'b0;
              wr_en     <= 1'b1;
              wr_addr   <= addr_of('0, row);
              wr_data   <= acc_upd[0];
              state     <= FLUSH;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        FLUSH: begin
          if (plane == PL_W'(PLANES - 1)) begin
            wr_en <= 1'b0;
            plane <= '0;
            if (row == ROW_W'(ROWS - 1)) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              row       <= row + ROW_W'(1);
              pix_ready <= 1'b1;
              state     <= COLLECT;
            end
          end else begin
            plane   <= plane_nxt;
            wr_addr <= addr_of(plane_nxt, row);
            wr_data <= acc[plane_nxt];
          end
        end
        DONE: begin
          if (frame_ack) begin
            frame_done <= 1'b0;
            row        <= '0;
            col        <= '0;
            pix_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcm_bitplane_packer.sv
// Bench for bcm_bitplane_packer: image-level model predicts every RAM write,
// handshake level, frame_done and sync_err cycle by cycle.
module tb_bcm_bitplane_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [63:0] wr_data;
  logic        frame_done;
  logic        frame_ack = 1'b0;
  logic        sync_err;

  bcm_bitplane_packer dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_ack(frame_ack),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [7:0]  src[16][64];
  logic [7:0]  img[16][64];
  logic [63:0] dut_ram[128];

  // Model: 0 = waiting for sof, 1 = in frame, 2 = frame complete
  int m_state = 0;
  int mr = 0, mc = 0;
  int fs = -10, fe = -10;
  int done_from = -1, done_to = -1;
  int sync_cyc = -1;
  int rst_from = 1, rst_to = 1 << 30;
  int last_xfer = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] row_word(input int r, input int p);
    logic [63:0] w = '0;
    for (int c = 0; c < 64; c++) w[63-c] = img[r][c][p];
    return w;
  endfunction

  task automatic model_xfer(input int t, input logic [7:0] d, input logic sof);
    if (m_state == 0) begin
      if (!sof) return;
      m_state = 1; mr = 0; mc = 0;
    end else if (m_state == 1) begin
      if (sof && (mr != 0 || mc != 0)) begin
        sync_cyc = t + 1; mr = 0; mc = 0;
      end
    end else begin
      return;
    end
    img[mr][mc] = d;
    mc++;
    if (mc == 64) begin
      for (int p = 0; p < 8; p++) begin
        wr_t e;
        e.cyc = t + 1 + p; e.addr = 7'(p * 16 + mr); e.data = row_word(mr, p);
        wq.push_back(e);
      end
      fs = t + 1; fe = t + 8; mc = 0;
      if (mr == 15) begin
        m_state = 2; done_from = t + 9; done_to = 1 << 30;
      end else begin
        mr++;
      end
    end
  endtask

  task automatic model_ack(input int a);
    if (m_state == 2 && a >= done_from) begin
      done_to = a + 1; m_state = 0;
    end
  endtask

  // Per-cycle compare against the model
  int n;
  bit exp_done, exp_ready;
  always @(negedge clk) begin
    n = cyc;
    if (n >= 1) begin
      if (n >= rst_from && n <= rst_to) begin
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sync_err", sync_err, 0);
      end else begin
        exp_done  = done_from >= 0 && n >= done_from && n < done_to;
        exp_ready = !(n >= fs && n <= fe) && !exp_done;
        check("pix_ready", pix_ready, exp_ready);
        check("frame_done", frame_done, exp_done);
        check("sync_err", sync_err, n == sync_cyc);
        while (wq.size() > 0 && wq[0].cyc < n) begin
          checks++; errors++;
          $display("FAIL missing_write cycle %0d: addr %h never written, required at cycle %0d",
                   n, wq[0].addr, wq[0].cyc);
          void'(wq.pop_front());
        end
        if (wq.size() > 0 && wq[0].cyc == n) begin
          check("wr_en", wr_en, 1);
          check("wr_addr", wr_addr, wq[0].addr);
          check("wr_data", wr_data, wq[0].data);
          void'(wq.pop_front());
        end else begin
          check("wr_en_idle", wr_en, 0);
        end
        if (wr_en === 1'b1) dut_ram[wr_addr] = wr_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_px(input logic [7:0] d, input logic sof, input int gap);
    int waited = 0;
    bit sent = 0;
    while (!sent) begin
      pix_data  = d;
      pix_sof   = sof;
      pix_valid = ($urandom_range(99) >= 32'(gap));
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        int t = cyc;
        tick();
        last_xfer = t;
        model_xfer(t, d, sof);
        sent = 1;
      end else begin
        tick();
        waited++;
        if (waited > 300) begin
          checks++; errors++;
          $display("FAIL xfer_timeout cycle %0d: pix_ready stuck at %b, required 1", cyc, pix_ready);
          sent = 1;
        end
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i < last; i++)
      send_px(src[i/64][i%64], i == 0, gap);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++) src[r][c] = 8'($urandom);
  endtask

  task automatic pulse_ack();
    int a;
    frame_ack = 1'b1;
    a = cyc;
    tick();
    frame_ack = 1'b0;
    model_ack(a);
  endtask

  task automatic wait_done_ack(output int seen);
    int k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
      k++;
    end
    seen = cyc;
    if (k >= 100) begin
      checks++; errors++;
      $display("FAIL done_timeout cycle %0d: frame_done %b, required 1", cyc, frame_done);
    end
    tick();
    pulse_ack();
  endtask

  task automatic assert_rst();
    wr_t keep[$];
    int a;
    rst = 1'b1;
    a = cyc;
    rst_from = a + 1; rst_to = 1 << 30;
    foreach (wq[i]) if (wq[i].cyc <= a) keep.push_back(wq[i]);
    wq = keep;
    m_state = 0; mr = 0; mc = 0;
    if (fe > a) fe = a;
    if (done_from > a) done_from = -1;
    else if (done_from >= 0 && done_to > a + 1) done_to = a + 1;
    if (sync_cyc > a) sync_cyc = -1;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    rst_to = cyc;
  endtask

  task automatic check_ram_vs_img(input string name);
    for (int a = 0; a < 128; a++) check(name, dut_ram[a], row_word(a % 16, a / 16));
  endtask

  initial begin
    int seen;
    logic [7:0] v;
    for (int a = 0; a < 128; a++) dut_ram[a] = 'x;
    repeat (3) tick();
    release_rst();

    // Pixel value = column
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++) src[r][c] = 8'(c);
    send_range(0, 1024, 0);
    wait_done_ack(seen);
    check("done_latency", 64'(seen - last_xfer), 64'd9);
    check("col_plane0_row0", dut_ram[0], 64'h5555_5555_5555_5555);
    check("col_plane0_row15", dut_ram[15], 64'h5555_5555_5555_5555);
    check("col_plane1_row2", dut_ram[18], 64'h3333_3333_3333_3333);
    check("col_plane5_row3", dut_ram[83], 64'h0000_0000_FFFF_FFFF);
    check("col_plane7_row8", dut_ram[120], 64'h0);

    // Single pixel A5 at row 9 col 0
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++) src[r][c] = 8'h00;
    src[9][0] = 8'hA5;
    send_range(0, 1024, 0);
    wait_done_ack(seen);
    v = 8'hA5;
    for (int a = 0; a < 128; a++)
      check("single_px", dut_ram[a], (a % 16 == 9 && v[a/16]) ? 64'h8000_0000_0000_0000 : 64'h0);

    // Random image with 50% valid gaps
    fill_random();
    send_range(0, 1024, 50);
    wait_done_ack(seen);
    check_ram_vs_img("gap_ram");

    // Resync at row 4 col 20
    fill_random();
    send_range(0, 4 * 64 + 20, 0);
    fill_random();
    send_range(0, 1024, 20);
    wait_done_ack(seen);
    check_ram_vs_img("resync_ram");

    // Discarded idle pixels and stray acks
    for (int i = 0; i < 10; i++) send_px(8'($urandom), 1'b0, 0);
    pulse_ack();
    fill_random();
    send_range(0, 30, 0);
    pulse_ack();
    send_range(30, 1024, 0);
    wait_done_ack(seen);
    check_ram_vs_img("stray_ack_ram");

    // Reset during the third write of a burst, then a fresh frame
    fill_random();
    send_range(0, 64, 0);
    tick();
    tick();
    assert_rst();
    tick();
    tick();
    release_rst();
    fill_random();
    send_range(0, 1024, 0);
    wait_done_ack(seen);
    check_ram_vs_img("post_rst_ram");

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
